// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns / InvMixColumns engine.
// Processes COLS_PER_CYCLE columns per RUN cycle between two valid/ready handshakes.
`timescale 1ns/1ps
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int C  = COLS_PER_CYCLE;
    localparam int N  = (C > 0) ? 4 / C : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(C == 1 || C == 2 || C == 4)) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e          st_q, st_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    src_q, src_d;
    logic [127:0]    res_q, res_d;
    logic            inv_q, inv_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // One column of the forward or inverse transform; coefficients rotate by row.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic m);
        logic [3:0][7:0] a, x2, x3, x9, xb, xd, xe, b;
        logic [7:0] x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = col[31-8*r -: 8];
            x2[r] = xt(a[r]);
            x4    = xt(x2[r]);
            x8    = xt(x4);
            x3[r] = x2[r] ^ a[r];
            x9[r] = x8 ^ a[r];
            xb[r] = x8 ^ x2[r] ^ a[r];
            xd[r] = x8 ^ x4 ^ a[r];
            xe[r] = x8 ^ x4 ^ x2[r];
        end
        for (int r = 0; r < 4; r++) begin
            if (m) begin
                b[r] = xe[r] ^ xb[(r+1)%4] ^ xd[(r+2)%4] ^ x9[(r+3)%4];
            end else begin
                b[r] = x2[r] ^ x3[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Next-state, column datapath and registered handshake outputs.
    always_comb begin
        st_d        = st_q;
        cnt_d       = cnt_q;
        src_d       = src_q;
        res_d       = res_q;
        inv_d       = inv_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        unique case (st_q)
            IDLE: begin
                if (in_valid) begin
                    src_d      = state_in;
                    inv_d      = inv;
                    cnt_d      = '0;
                    st_d       = RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            RUN: begin
                for (int i = 0; i < C; i++) begin
                    res_d[127-32*(int'(cnt_q)*C+i) -: 32] =
                        mix_col(src_q[127-32*(int'(cnt_q)*C+i) -: 32], inv_q);
                end
                if (int'(cnt_q) == N - 1) begin
                    st_d        = DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    st_d        = IDLE;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                st_d        = IDLE;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset discards any block in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            src_q       <= '0;
            res_q       <= '0;
            inv_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            src_q       <= src_d;
            res_q       <= res_d;
            inv_q       <= inv_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = res_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle)
// checked against a generic GF(2^8) matrix model.
`timescale 1ns/1ps
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         iv[3], ir[3], inv_s[3], ov[3], ordy[3], bsy[3];
    logic [127:0] si[3], so[3];
    int           tests = 0;
    int           failed = 0;
    int           ncyc[3] = '{4, 2, 1};

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .inv(inv_s[0]), .state_in(si[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .state_out(so[0]), .busy(bsy[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .inv(inv_s[1]), .state_in(si[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .state_out(so[1]), .busy(bsy[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .inv(inv_s[2]), .state_in(si[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .state_out(so[2]), .busy(bsy[2]));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = (x << 1) ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic m);
        logic [7:0]   base[4];
        logic [7:0]   acc;
        logic [127:0] res = '0;
        if (m) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc ^= gmul(s[127-32*c-8*j -: 8], base[(j-r+4)%4]);
                end
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input int k, input string tag);
        chk({tag, "_in_ready"}, 128'(ir[k]), 128'd1);
        chk({tag, "_out_valid"}, 128'(ov[k]), 128'd0);
        chk({tag, "_state_out"}, so[k], 128'h0);
        chk({tag, "_busy"}, 128'(bsy[k]), 128'd0);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with out_valid high.
    task automatic run_block(input int k, input logic [127:0] d, input logic m,
                             output logic [127:0] r, output int lat);
        iv[k] = 1'b1; si[k] = d; inv_s[k] = m;
        @(posedge clk); #1;
        iv[k] = 1'b0; si[k] = ~d; inv_s[k] = ~m;
        lat = 0;
        while (!ov[k] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        r = so[k];
    endtask

    task automatic consume(input int k);
        ordy[k] = 1'b1;
        @(posedge clk); #1;
        ordy[k] = 1'b0;
        chk("out_valid_drop", 128'(ov[k]), 128'd0);
    endtask

    task automatic directed(input int k, input logic [127:0] d, input logic m,
                            input logic [127:0] exp, input string tag);
        logic [127:0] r;
        int lat;
        run_block(k, d, m, r, lat);
        chk({tag, "_latency"}, 128'(lat), 128'(ncyc[k]));
        chk({tag, "_const"}, r, exp);
        chk({tag, "_model"}, r, model(d, m));
        consume(k);
    endtask

    task automatic stream(input int k);
        logic [127:0] q[$];
        logic [127:0] pd, pso;
        logic pv, pr, pm, pov, pordy;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < 100 && cyc < 8000) begin
            iv[k] = (sent < 100) && ($urandom_range(0, 3) != 0);
            si[k] = {$urandom, $urandom, $urandom, $urandom};
            inv_s[k] = 1'($urandom_range(0, 1));
            ordy[k] = ($urandom_range(0, 2) != 0);
            pv = iv[k]; pr = ir[k]; pd = si[k]; pm = inv_s[k];
            pov = ov[k]; pordy = ordy[k]; pso = so[k];
            @(posedge clk); #1;
            cyc++;
            if (pv && pr) begin
                q.push_back(model(pd, pm));
                sent++;
            end
            if (pov && pordy) begin
                chk("stream_nonempty", 128'(q.size() != 0), 128'd1);
                if (q.size() != 0) chk("stream_data", pso, q.pop_front());
                got++;
            end
        end
        iv[k] = 1'b0;
        ordy[k] = 1'b0;
        chk("stream_count", 128'(got), 128'd100);
        chk("stream_leftover", 128'(q.size()), 128'd0);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] C6_IN    = 128'hc6c6c6c6_d4d4d4d5_d4d4d4d5_c6c6c6c6;
    localparam logic [127:0] C6_OUT   = 128'hc6c6c6c6_d5d5d7d6_d5d5d7d6_c6c6c6c6;

    initial begin
        logic [127:0] r, y, z;
        int lat;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; inv_s[k] = 1'b0; ordy[k] = 1'b0; si[k] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_idle(k, "reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 3; k++) begin
            directed(k, FIPS_IN, 1'b0, FIPS_OUT, "fips_fwd");
            directed(k, FIPS_OUT, 1'b1, FIPS_IN, "fips_inv");
            directed(k, C6_IN, 1'b0, C6_OUT, "c6_fwd");
            directed(k, C6_OUT, 1'b1, C6_IN, "c6_inv");
        end

        y = {$urandom, $urandom, $urandom, $urandom};
        run_block(0, FIPS_IN ^ y, 1'b0, r, lat);
        chk("bp_first", r, model(FIPS_IN ^ y, 1'b0));
        iv[0] = 1'b1; si[0] = y; inv_s[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 128'(ov[0]), 128'd1);
            chk("bp_state_out", so[0], r);
            chk("bp_in_ready", 128'(ir[0]), 128'd0);
            chk("bp_busy", 128'(bsy[0]), 128'd1);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        ordy[0] = 1'b0;
        chk("bp_release_ov", 128'(ov[0]), 128'd0);
        chk("bp_release_ir", 128'(ir[0]), 128'd1);
        @(posedge clk); #1;
        iv[0] = 1'b0; si[0] = '0; inv_s[0] = 1'b0;
        chk("bp_taken_busy", 128'(bsy[0]), 128'd1);
        lat = 0;
        while (!ov[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("bp_second_lat", 128'(lat), 128'd4);
        chk("bp_second", so[0], model(y, 1'b1));
        consume(0);

        z = {$urandom, $urandom, $urandom, $urandom};
        iv[0] = 1'b1; si[0] = z; inv_s[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_idle(0, "midrst");
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_stale", 128'(ov[0]), 128'd0);
        end
        run_block(0, z, 1'b1, r, lat);
        chk("midrst_fresh_lat", 128'(lat), 128'd4);
        chk("midrst_fresh", r, model(z, 1'b1));
        consume(0);

        for (int k = 0; k < 3; k++) stream(k);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Sequential, parametrised AES MixColumns / InvMixColumns engine for the 128-bit AES datapath. It consumes a full 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock using GF(2^8) xtime arithmetic. The forward or inverse transform is selected per block. It presents the result on a second valid/ready handshake. It sits between ShiftRows and AddRoundKey in the round pipeline and is shared by the encrypt and decrypt paths.

## Interface
- COLS_PER_CYCLE, 1, columns processed per RUN cycle; legal values are 1, 2 and 4; any other value is an elaboration error.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  input block valid.
- in_ready  output  1  engine can accept a block; high only in IDLE.
- inv  input  1  mode, sampled with the block: 0 = MixColumns, 1 = InvMixColumns.
- state_in  input  128  input state. Column c = state_in[127-32c -: 32]; row r of that column = byte [127-32c-8r -: 8].
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  downstream accepts the result.
- state_out  output  128  result, in the same byte order as state_in; registered.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE:**
  - in_ready = 1.
  - On in_valid && in_ready: capture state_in and inv, clear the column counter, go to RUN.
- **RUN:**
  - Each cycle, transform columns [cnt*C, cnt*C+C-1], with C = COLS_PER_CYCLE.
  - Write the results into the same column slots of the result register.
  - cnt increments by 1 per cycle.
  - After N = 4/C RUN cycles, go to DONE.
  - Input changes during RUN are ignored; captured state and mode are used.
- **DONE:**
  - out_valid = 1 and state_out stable.
  - On out_ready, go to IDLE; out_valid drops on the next edge.
  - With out_ready held low, hold indefinitely.
- **Forward transform**, per column a0..a3:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- **Inverse transform**, same rotation pattern with coefficients {0e,0b,0d,09}:
  - b0 = 0e·a0^0b·a1^0d·a2^09·a3, rotated for b1..b3.
- **Arithmetic:**
  - xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1B : 0).
  - 3x = xtime(x)^x.
  - 09/0b/0d/0e are built from three chained xtimes plus XOR.
  - All values are 8-bit, with no carries beyond bit 7.
- Columns not yet processed hold undefined intermediate content internally. They are never visible, because out_valid gates state_out.
- No overlap: a new block is accepted only after the previous result is consumed.

## Timing
- **Reset** (asynchronous, rst_n low), regardless of current state:
  - State = IDLE, cnt = 0, out_valid = 0, busy = 0, state_out = 128'h0, captured mode = 0.
  - in_ready = 1 once in IDLE.
- **Reset mid-operation:** the block in flight is discarded and no out_valid is produced. The first handshake after rst_n rises is a fresh block.
- **Latency:** accept at edge E gives out_valid high after edge E+N. N = 4, 2 or 1 for C = 1, 2 or 4.
- **Throughput:** at most one block per N+2 cycles (accept cycle, N RUN cycles, DONE cycle) with out_ready held high.
- **Handshake rules:**
  - in_ready depends only on state, never combinationally on in_valid.
  - out_valid, once high, stays high with state_out constant until out_ready is sampled high.
- **Simultaneous events:** in_valid in the same cycle as DONE&&out_ready is not accepted. in_ready is 0 in DONE, and the block is taken in the following IDLE cycle.
- **Counter wrap:** cnt is log2(N) bits; it is cleared on accept and never wraps inside RUN.

## Test plan
- **Forward, FIPS-197 columns:**
  - Stimulus: state_in = db135345_f20a225c_01010101_2d26314c, inv = 0, C = 1.
  - Required: state_out = 8e4da1bc_9fdc589d_01010101_4d7ebdf8; out_valid rises 4 cycles after accept.
- **Inverse round-trip:**
  - Stimulus: feed 8e4da1bc_9fdc589d_01010101_4d7ebdf8 with inv = 1.
  - Required: db135345_f20a225c_01010101_2d26314c.
  - Also check c6c6c6c6 and d4d4d4d5 columns: forward maps them to c6c6c6c6 and d5d5d7d6, and inverse maps them back.
- **Parameter sweep:**
  - Repeat the first two tests for C = 2 and C = 4.
  - Required: identical results, with latency 2 and 1 cycles respectively.
- **Backpressure:**
  - Stimulus: hold out_ready = 0 for 10 cycles after out_valid.
  - Required: out_valid and state_out stable, in_ready = 0, busy = 1 throughout; a block offered on in_valid is not taken until after out_ready.
- **Reset mid-RUN:**
  - Stimulus: assert rst_n = 0 on cycle 2 of RUN (C = 1).
  - Required: out_valid = 0, state_out = 0 and in_ready = 1 immediately; no stale result appears; the next block gives the correct result.
- **Back-to-back stream:**
  - Stimulus: 100 random blocks with random inv and random out_ready/in_valid gaps.
  - Required: every result matches the reference model, in order, with no drops or duplicates.
